tlc_monitor: RTL and testbench

- Receive-side checker for the traffic-light controller's one-hot r/y/g outputs.
- Samples the three lamp lines every clock, decodes the current phase, and measures how long each phase lasts (dwell).
- Checks the required order red→yellow→green→red and the exact dwell of each phase.
- Reports the decoded phase, completed-cycle events and sticky error flags; used as an in-system safety watchdog and as a bench scoreboard.

---
 rtl/tlc_monitor.sv | 262 ++++++++++++++++++++++++++
 tb/tb_tlc_monitor.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_monitor.sv
// -----------------------------------------------------------------------------
// tlc_monitor
//
// Receive-side checker for a traffic-light controller's one-hot lamp outputs.
// Each clock the r/y/g lines are sampled, the phase is decoded, and the time
// spent in each phase (dwell) is counted. The checker verifies the order
// red -> yellow -> green -> red and the exact dwell of every phase. It reports
// the decoded phase, a pulse per completed legal cycle, and sticky error flags.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   r, y, g      in   lamp lines, same clock domain
//   err_clear    in   one-cycle pulse: clear errors and resynchronise
//   phase        out  00 red, 01 yellow, 10 green, 11 unsynced/fault
//   synced       out  high while a legal sequence is being tracked
//   dwell        out  cycles the current phase has been observed (saturating)
//   cycle_done   out  one-cycle pulse on each legal green->red transition
//   cycle_count  out  number of completed legal cycles, wraps 255->0
//   err_valid    out  sticky: any error since reset / err_clear
//   err_code     out  sticky: [0] not one-hot, [1] illegal order, [2] dwell
//
// All outputs are registered and reflect the lamp sample taken at the same
// rising edge (one cycle of latency).
// -----------------------------------------------------------------------------
module tlc_monitor #(
    parameter int RED_DWELL = 31,
    parameter int YEL_DWELL = 11,
    parameter int GRN_DWELL = 31,
    parameter int CW        = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          r,
    input  logic          y,
    input  logic          g,
    input  logic          err_clear,
    output logic [1:0]    phase,
    output logic          synced,
    output logic [CW-1:0] dwell,
    output logic          cycle_done,
    output logic [7:0]    cycle_count,
    output logic          err_valid,
    output logic [2:0]    err_code
);

    typedef enum logic [2:0] {
        S_UNSYNC,
        S_RED,
        S_YEL,
        S_GRN,
        S_FAULT
    } state_t;

    // Lamp codes share the encoding of the phase output.
    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;
    localparam logic [1:0] C_NONE = 2'b11;

    state_t        r_state, r_state_next;
    logic [CW-1:0] r_dwell, r_dwell_next;
    logic [1:0]    r_phase, r_phase_next;
    logic          r_synced, r_synced_next;
    logic          r_cycle_done, r_cycle_done_next;
    logic [7:0]    r_cycle_count, r_cycle_count_next;
    logic [2:0]    r_err_code, r_err_code_next;
    logic          r_err_valid, r_err_valid_next;
    // Last valid lamp seen, used only to find the first lamp change in UNSYNC.
    logic [1:0]    r_last, r_last_next;
    logic          r_last_valid, r_last_valid_next;

    logic          w_onehot;
    logic [1:0]    w_lamp;
    logic [1:0]    w_cur;
    logic [1:0]    w_succ;
    logic [CW-1:0] w_req;
    logic [CW-1:0] w_dwell_inc;

    function automatic state_t code_to_state(input logic [1:0] code);
        case (code)
            C_RED:   return S_RED;
            C_YEL:   return S_YEL;
            C_GRN:   return S_GRN;
            default: return S_FAULT;
        endcase
    endfunction

    // Lamp decode: a sample is only valid when exactly one lamp is lit.
    always_comb begin
        w_onehot = 1'b1;
        w_lamp   = C_NONE;
        case ({r, y, g})
            3'b100:  w_lamp = C_RED;
            3'b010:  w_lamp = C_YEL;
            3'b001:  w_lamp = C_GRN;
            default: w_onehot = 1'b0;
        endcase
    end

    // Current phase code, its legal successor and its required dwell.
    always_comb begin
        w_cur  = C_NONE;
        w_succ = C_NONE;
        w_req  = '0;
        case (r_state)
            S_RED: begin
                w_cur  = C_RED;
                w_succ = C_YEL;
                w_req  = CW'(RED_DWELL);
            end
            S_YEL: begin
                w_cur  = C_YEL;
                w_succ = C_GRN;
                w_req  = CW'(YEL_DWELL);
            end
            S_GRN: begin
                w_cur  = C_GRN;
                w_succ = C_RED;
                w_req  = CW'(GRN_DWELL);
            end
            default: ;
        endcase
    end

    assign w_dwell_inc = (r_dwell == {CW{1'b1}}) ? r_dwell : r_dwell + 1'b1;

    always_comb begin
        r_state_next       = r_state;
        r_dwell_next       = r_dwell;
        r_cycle_done_next  = 1'b0;
        r_cycle_count_next = r_cycle_count;
        r_err_code_next    = r_err_code;
        r_last_next        = r_last;
        r_last_valid_next  = r_last_valid;

        if (w_onehot) begin
            r_last_next       = w_lamp;
            r_last_valid_next = 1'b1;
        end

        if (err_clear) begin
            // Clear overrides anything detected in this same sample; the
            // current sample still seeds the change detector for resync.
            r_state_next      = S_UNSYNC;
            r_dwell_next      = '0;
            r_err_code_next   = 3'b000;
            r_last_valid_next = w_onehot;
        end else begin
            case (r_state)
                S_UNSYNC: begin
                    // The phase in progress at reset has unknown elapsed time,
                    // so tracking starts only at the first lamp change.
                    if (!w_onehot) begin
                        r_err_code_next[0] = 1'b1;
                        r_state_next       = S_FAULT;
                    end else if (r_last_valid && (w_lamp != r_last)) begin
                        r_state_next = code_to_state(w_lamp);
                        r_dwell_next = CW'(1);
                    end
                end

                S_RED, S_YEL, S_GRN: begin
                    if (!w_onehot) begin
                        r_err_code_next[0] = 1'b1;
                        r_state_next       = S_FAULT;
                        r_dwell_next       = '0;
                    end else if (w_lamp == w_cur) begin
                        // Overrun is flagged as soon as the dwell would pass
                        // the requirement, without waiting for a lamp change.
                        if (r_dwell >= w_req) begin
                            r_err_code_next[2] = 1'b1;
                            r_state_next       = S_FAULT;
                            r_dwell_next       = '0;
                        end else begin
                            r_dwell_next = w_dwell_inc;
                        end
                    end else if (w_lamp == w_succ) begin
                        if (r_dwell != w_req) begin
                            r_err_code_next[2] = 1'b1;
                            r_state_next       = S_FAULT;
                            r_dwell_next       = '0;
                        end else begin
                            r_state_next = code_to_state(w_succ);
                            r_dwell_next = CW'(1);
                            if (r_state == S_GRN) begin
                                r_cycle_done_next  = 1'b1;
                                r_cycle_count_next = r_cycle_count + 8'd1;
                            end
                        end
                    end else begin
                        // Valid lamp, wrong order; the dwell is judged too.
                        r_err_code_next[1] = 1'b1;
                        if (r_dwell != w_req) begin
                            r_err_code_next[2] = 1'b1;
                        end
                        r_state_next = S_FAULT;
                        r_dwell_next = '0;
                    end
                end

                S_FAULT: begin
                    r_dwell_next = '0;
                    if (!w_onehot) begin
                        r_err_code_next[0] = 1'b1;
                    end
                end

                default: begin
                    r_state_next = S_UNSYNC;
                    r_dwell_next = '0;
                end
            endcase
        end

        r_synced_next    = (r_state_next == S_RED) || (r_state_next == S_YEL) ||
                           (r_state_next == S_GRN);
        r_phase_next     = C_NONE;
        case (r_state_next)
            S_RED:   r_phase_next = C_RED;
            S_YEL:   r_phase_next = C_YEL;
            S_GRN:   r_phase_next = C_GRN;
            default: r_phase_next = C_NONE;
        endcase
        r_err_valid_next = |r_err_code_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_UNSYNC;
            r_dwell       <= '0;
            r_phase       <= C_NONE;
            r_synced      <= 1'b0;
            r_cycle_done  <= 1'b0;
            r_cycle_count <= 8'd0;
            r_err_code    <= 3'b000;
            r_err_valid   <= 1'b0;
            r_last        <= C_NONE;
            r_last_valid  <= 1'b0;
        end else begin
            r_state       <= r_state_next;
            r_dwell       <= r_dwell_next;
            r_phase       <= r_phase_next;
            r_synced      <= r_synced_next;
            r_cycle_done  <= r_cycle_done_next;
            r_cycle_count <= r_cycle_count_next;
            r_err_code    <= r_err_code_next;
            r_err_valid   <= r_err_valid_next;
            r_last        <= r_last_next;
            r_last_valid  <= r_last_valid_next;
        end
    end

    assign phase       = r_phase;
    assign synced      = r_synced;
    assign dwell       = r_dwell;
    assign cycle_done  = r_cycle_done;
    assign cycle_count = r_cycle_count;
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_tlc_monitor.sv
// -----------------------------------------------------------------------------
// tb_tlc_monitor
//
// Directed bench for tlc_monitor. Each task drives one scenario and checks the
// registered outputs 1 time unit after the rising edge that took the sample.
// -----------------------------------------------------------------------------
module tb_tlc_monitor;

    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          r = 1'b0;
    logic          y = 1'b0;
    logic          g = 1'b0;
    logic          err_clear = 1'b0;
    logic [1:0]    phase;
    logic          synced;
    logic [CW-1:0] dwell;
    logic          cycle_done;
    logic [7:0]    cycle_count;
    logic          err_valid;
    logic [2:0]    err_code;

    int n_compared   = 0;
    int n_mismatched = 0;

    tlc_monitor #(
        .RED_DWELL(31),
        .YEL_DWELL(11),
        .GRN_DWELL(31),
        .CW(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .r(r),
        .y(y),
        .g(g),
        .err_clear(err_clear),
        .phase(phase),
        .synced(synced),
        .dwell(dwell),
        .cycle_done(cycle_done),
        .cycle_count(cycle_count),
        .err_valid(err_valid),
        .err_code(err_code)
    );

    always #5 clock = ~clock;

    // Apply one lamp sample and wait until just after the edge that takes it.
    task automatic step(input logic ir, input logic iy, input logic ig);
        r = ir;
        y = iy;
        g = ig;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ir, input logic iy, input logic ig, input int n);
        for (int i = 0; i < n; i++) step(ir, iy, ig);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        n_compared++;
        if (phase !== 2'b11) begin
            n_mismatched++;
            $display("FAIL reset_phase: got %b expected 11", phase);
        end
        n_compared++;
        if (synced !== 1'b0 || dwell !== '0 || cycle_done !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_sync_dwell_done: got %b %0d %b expected 0 0 0", synced, dwell, cycle_done);
        end
        n_compared++;
        if (cycle_count !== 8'd0 || err_valid !== 1'b0 || err_code !== 3'b000) begin
            n_mismatched++;
            $display("FAIL reset_count_err: got %0d %b %b expected 0 0 000", cycle_count, err_valid, err_code);
        end
        $display("test_reset done: phase=%b err_code=%b", phase, err_code);
    endtask

    // Nominal controller sequence, three full cycles plus one closing red.
    // Sync happens at the first red->yellow edge, so the first red is untracked.
    task automatic test_nominal();
        logic [1:0]    exp_phase;
        logic [CW-1:0] exp_dwell;
        logic          exp_done;
        logic          exp_sync;
        int            len;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 3; p++) begin
                len = (p == 1) ? 11 : 31;
                for (int i = 0; i < len; i++) begin
                    step(p == 0, p == 1, p == 2);
                    exp_sync  = !(c == 0 && p == 0);
                    exp_phase = exp_sync ? 2'(p) : 2'b11;
                    exp_dwell = exp_sync ? CW'(i + 1) : '0;
                    exp_done  = (p == 0 && i == 0 && c > 0);
                    n_compared++;
                    if (phase !== exp_phase || synced !== exp_sync) begin
                        n_mismatched++;
                        $display("FAIL nominal_phase c%0d p%0d i%0d: got %b/%b expected %b/%b",
                                 c, p, i, phase, synced, exp_phase, exp_sync);
                    end
                    n_compared++;
                    if (dwell !== exp_dwell) begin
                        n_mismatched++;
                        $display("FAIL nominal_dwell c%0d p%0d i%0d: got %0d expected %0d",
                                 c, p, i, dwell, exp_dwell);
                    end
                    n_compared++;
                    if (cycle_done !== exp_done || cycle_count !== 8'(c)) begin
                        n_mismatched++;
                        $display("FAIL nominal_cycle c%0d p%0d i%0d: got done=%b cnt=%0d expected done=%b cnt=%0d",
                                 c, p, i, cycle_done, cycle_count, exp_done, c);
                    end
                    n_compared++;
                    if (err_valid !== 1'b0 || err_code !== 3'b000) begin
                        n_mismatched++;
                        $display("FAIL nominal_err c%0d p%0d i%0d: got %b/%b expected 0/000",
                                 c, p, i, err_valid, err_code);
                    end
                end
            end
        end
        step(1'b1, 1'b0, 1'b0);
        n_compared++;
        if (cycle_done !== 1'b1 || cycle_count !== 8'd3 || phase !== 2'b00 || dwell !== CW'(1)) begin
            n_mismatched++;
            $display("FAIL nominal_final: got done=%b cnt=%0d phase=%b dwell=%0d expected 1 3 00 1",
                     cycle_done, cycle_count, phase, dwell);
        end
        step(1'b1, 1'b0, 1'b0);
        n_compared++;
        if (cycle_done !== 1'b0 || cycle_count !== 8'd3) begin
            n_mismatched++;
            $display("FAIL nominal_done_pulse: got done=%b cnt=%0d expected 0 3", cycle_done, cycle_count);
        end
        $display("test_nominal done: cycle_count=%0d", cycle_count);
    endtask

    // After the nominal run: a bad pattern, then a clear that coincides with
    // another bad pattern. cycle_count must survive the clear.
    task automatic test_clear_keeps_count();
        step(1'b0, 1'b0, 1'b0);
        n_compared++;
        if (err_code !== 3'b001 || err_valid !== 1'b1 || phase !== 2'b11 || cycle_count !== 8'd3) begin
            n_mismatched++;
            $display("FAIL zero_lamps: got err=%b v=%b phase=%b cnt=%0d expected 001 1 11 3",
                     err_code, err_valid, phase, cycle_count);
        end
        err_clear = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        err_clear = 1'b0;
        n_compared++;
        if (err_code !== 3'b000 || err_valid !== 1'b0 || phase !== 2'b11 || cycle_count !== 8'd3) begin
            n_mismatched++;
            $display("FAIL clear_wins: got err=%b v=%b phase=%b cnt=%0d expected 000 0 11 3",
                     err_code, err_valid, phase, cycle_count);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_compared++;
        if (phase !== 2'b01 || synced !== 1'b1 || dwell !== CW'(1) || cycle_count !== 8'd3) begin
            n_mismatched++;
            $display("FAIL clear_resync: got phase=%b sync=%b dwell=%0d cnt=%0d expected 01 1 1 3",
                     phase, synced, dwell, cycle_count);
        end
        $display("test_clear_keeps_count done: err_code=%b cycle_count=%0d", err_code, cycle_count);
    endtask

    // Reset and err_clear together mid-yellow; then the partial yellow after
    // reset is not dwell-checked, and the first green->red after sync counts.
    task automatic test_reset_priority();
        drive(1'b0, 1'b1, 1'b0, 4);
        reset     = 1'b1;
        err_clear = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        reset     = 1'b0;
        err_clear = 1'b0;
        n_compared++;
        if (phase !== 2'b11 || synced !== 1'b0 || dwell !== '0 || cycle_done !== 1'b0 ||
            cycle_count !== 8'd0 || err_valid !== 1'b0 || err_code !== 3'b000) begin
            n_mismatched++;
            $display("FAIL reset_prio: got phase=%b sync=%b dwell=%0d done=%b cnt=%0d v=%b err=%b expected reset values",
                     phase, synced, dwell, cycle_done, cycle_count, err_valid, err_code);
        end
        drive(1'b0, 1'b1, 1'b0, 3);
        step(1'b0, 1'b0, 1'b1);
        n_compared++;
        if (phase !== 2'b10 || dwell !== CW'(1) || err_code !== 3'b000) begin
            n_mismatched++;
            $display("FAIL partial_unchecked: got phase=%b dwell=%0d err=%b expected 10 1 000",
                     phase, dwell, err_code);
        end
        drive(1'b0, 1'b0, 1'b1, 30);
        step(1'b1, 1'b0, 1'b0);
        n_compared++;
        if (cycle_done !== 1'b1 || cycle_count !== 8'd1 || err_code !== 3'b000) begin
            n_mismatched++;
            $display("FAIL first_cycle_counts: got done=%b cnt=%0d err=%b expected 1 1 000",
                     cycle_done, cycle_count, err_code);
        end
        $display("test_reset_priority done: cycle_count=%0d", cycle_count);
    endtask

    task automatic test_underrun();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b0, 31);
        drive(1'b0, 1'b1, 1'b0, 10);
        n_compared++;
        if (phase !== 2'b01 || dwell !== CW'(10) || err_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL underrun_pre: got phase=%b dwell=%0d v=%b expected 01 10 0", phase, dwell, err_valid);
        end
        step(1'b0, 1'b0, 1'b1);
        n_compared++;
        if (err_code !== 3'b100 || err_valid !== 1'b1 || phase !== 2'b11 || synced !== 1'b0) begin
            n_mismatched++;
            $display("FAIL underrun: got err=%b v=%b phase=%b sync=%b expected 100 1 11 0",
                     err_code, err_valid, phase, synced);
        end
        $display("test_underrun done: err_code=%b", err_code);
    endtask

    task automatic test_overrun();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b0, 31);
        n_compared++;
        if (phase !== 2'b00 || dwell !== CW'(31) || err_code !== 3'b000) begin
            n_mismatched++;
            $display("FAIL overrun_boundary: got phase=%b dwell=%0d err=%b expected 00 31 000", phase, dwell, err_code);
        end
        step(1'b1, 1'b0, 1'b0);
        n_compared++;
        if (err_code !== 3'b100 || err_valid !== 1'b1 || phase !== 2'b11 || dwell !== '0) begin
            n_mismatched++;
            $display("FAIL overrun: got err=%b v=%b phase=%b dwell=%0d expected 100 1 11 0",
                     err_code, err_valid, phase, dwell);
        end
        $display("test_overrun done: err_code=%b", err_code);
    endtask

    task automatic test_not_onehot();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b0, 5);
        step(1'b1, 1'b0, 1'b1);
        n_compared++;
        if (err_code !== 3'b001 || err_valid !== 1'b1 || phase !== 2'b11) begin
            n_mismatched++;
            $display("FAIL not_onehot: got err=%b v=%b phase=%b expected 001 1 11", err_code, err_valid, phase);
        end
        step(1'b1, 1'b0, 1'b0);
        n_compared++;
        if (err_code !== 3'b001 || phase !== 2'b11) begin
            n_mismatched++;
            $display("FAIL fault_hold: got err=%b phase=%b expected 001 11", err_code, phase);
        end
        err_clear = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        err_clear = 1'b0;
        n_compared++;
        if (err_code !== 3'b000 || err_valid !== 1'b0 || phase !== 2'b11) begin
            n_mismatched++;
            $display("FAIL err_clear: got err=%b v=%b phase=%b expected 000 0 11", err_code, err_valid, phase);
        end
        drive(1'b1, 1'b0, 1'b0, 2);
        n_compared++;
        if (phase !== 2'b11 || synced !== 1'b0) begin
            n_mismatched++;
            $display("FAIL no_early_sync: got phase=%b sync=%b expected 11 0", phase, synced);
        end
        step(1'b0, 1'b1, 1'b0);
        n_compared++;
        if (phase !== 2'b01 || synced !== 1'b1 || dwell !== CW'(1) || err_code !== 3'b000) begin
            n_mismatched++;
            $display("FAIL resync: got phase=%b sync=%b dwell=%0d err=%b expected 01 1 1 000",
                     phase, synced, dwell, err_code);
        end
        $display("test_not_onehot done: phase=%b", phase);
    endtask

    task automatic test_order();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b0, 31);
        step(1'b0, 1'b0, 1'b1);
        n_compared++;
        if (err_code !== 3'b010 || err_valid !== 1'b1 || phase !== 2'b11) begin
            n_mismatched++;
            $display("FAIL order: got err=%b v=%b phase=%b expected 010 1 11", err_code, err_valid, phase);
        end
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b0, 5);
        step(1'b0, 1'b0, 1'b1);
        n_compared++;
        if (err_code !== 3'b110 || err_valid !== 1'b1) begin
            n_mismatched++;
            $display("FAIL order_and_dwell: got err=%b v=%b expected 110 1", err_code, err_valid);
        end
        $display("test_order done: err_code=%b", err_code);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_clear_keeps_count();
        test_reset_priority();
        test_underrun();
        test_overrun();
        test_not_onehot();
        test_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
